// File: rtl/nonce_collector.sv
// nonce_collector: round-robin harvester that reads winning nonces from the hash macros into a pop FIFO.
// Build option NONCE_COLLECTOR_OVERWRITE_EN: a full FIFO drops its oldest entry instead of back-pressuring.
module nonce_collector #(
    parameter int         NUM_MACROS = 4,
    parameter logic [5:0] NONCE_BASE = 6'h00,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                  SPI_CLK,
    input  logic                  RST,
    input  logic                  scan_enable,
    input  logic [NUM_MACROS-1:0] DATA_AVAILABLE,
    output logic [NUM_MACROS-1:0] MACRO_RD_SELECT,
    output logic [5:0]            HASH_ADDR,
    input  logic [7:0]            DATA_FROM_HASH,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [3:0]            head_macro,
    output logic [31:0]           head_nonce,
    output logic [4:0]            fifo_count,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic                  irq
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH    = 5'(FIFO_DEPTH);
    localparam logic [3:0] LAST_PTR = 4'(NUM_MACROS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, READ, PUSH, HOLDOFF} state_t;

    typedef struct packed {
        logic [3:0]  macro;
        logic [31:0] nonce;
    } entry_t;

    state_t        state;
    logic [3:0]    ptr;
    logic [1:0]    byte_idx;
    logic          holdoff_cnt;
    logic [31:0]   nonce_acc;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;

    logic                  flag_sel;
    logic [NUM_MACROS-1:0] sel_onehot;
    logic [3:0]            next_ptr;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        flag_sel   = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_MACROS; i++) begin
            if (ptr == 4'(i)) begin
                flag_sel      = DATA_AVAILABLE[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign next_ptr = (ptr == LAST_PTR) ? 4'd0 : ptr + 4'd1;

    logic push;
    logic full;
    logic pop_eff;
    logic push_eff;
    logic drop;
    logic can_accept;

    assign push    = (state == PUSH);
    assign full    = (fifo_count == DEPTH);
    assign pop_eff = pop && (fifo_count != 5'd0);

`ifdef NONCE_COLLECTOR_OVERWRITE_EN
    assign can_accept = 1'b1;
    assign push_eff   = push;
    assign drop       = push && full && !pop_eff;
`else
    assign can_accept = !full;
    assign push_eff   = push && (!full || pop_eff);
    assign drop       = 1'b0;
`endif

    logic          advance_head;
    logic [AW-1:0] head_nxt;
    logic [4:0]    count_nxt;
    entry_t        push_entry;
    entry_t        head_entry_nxt;

    assign advance_head = pop_eff || drop;
    assign head_nxt     = advance_head ? head_ptr + AW'(1) : head_ptr;
    assign count_nxt    = fifo_count + (push_eff ? 5'd1 : 5'd0) - (advance_head ? 5'd1 : 5'd0);
    assign push_entry   = '{macro: ptr, nonce: nonce_acc};

    // A push into the slot that becomes head must bypass the array to keep head_* registered.
    always_comb begin
        head_entry_nxt = mem[head_nxt];
        if (push_eff && (tail_ptr == head_nxt)) begin
            head_entry_nxt = push_entry;
        end
    end

    // NOTE: the entry array is deliberately not reset; head_* are forced to 0 while empty so stale slots never leak.
    always_ff @(posedge SPI_CLK) begin
        if (push_eff) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fifo_count <= '0;
            head_valid <= 1'b0;
            irq        <= 1'b0;
            head_macro <= '0;
            head_nonce <= '0;
            overflow   <= 1'b0;
        end else begin
            head_ptr   <= head_nxt;
            fifo_count <= count_nxt;
            head_valid <= (count_nxt != 5'd0);
            irq        <= (count_nxt != 5'd0);
            if (push_eff) begin
                tail_ptr <= tail_ptr + AW'(1);
            end
            if (count_nxt != 5'd0) begin
                head_macro <= head_entry_nxt.macro;
                head_nonce <= head_entry_nxt.nonce;
            end else begin
                head_macro <= '0;
                head_nonce <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Scan/read sequencer; select and address are registered so they change exactly on state entry.
    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            state           <= IDLE;
            ptr             <= '0;
            byte_idx        <= '0;
            holdoff_cnt     <= 1'b0;
            nonce_acc       <= '0;
            MACRO_RD_SELECT <= '0;
            HASH_ADDR       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_enable && flag_sel && can_accept) begin
                        state           <= ADDR;
                        MACRO_RD_SELECT <= sel_onehot;
                        HASH_ADDR       <= NONCE_BASE;
                    end else if (scan_enable && can_accept) begin
                        ptr <= next_ptr;
                    end
                end
                ADDR: begin
                    state     <= READ;
                    byte_idx  <= 2'd0;
                    HASH_ADDR <= NONCE_BASE + 6'd1;
                end
                READ: begin
                    // Bytes shift in from the top so byte 0 lands in [7:0] after four reads.
                    nonce_acc <= {DATA_FROM_HASH, nonce_acc[31:8]};
                    if (byte_idx == 2'd3) begin
                        state           <= PUSH;
                        MACRO_RD_SELECT <= '0;
                        HASH_ADDR       <= '0;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx != 2'd2) begin
                            HASH_ADDR <= NONCE_BASE + {4'd0, byte_idx} + 6'd2;
                        end
                    end
                end
                PUSH: begin
                    state       <= HOLDOFF;
                    holdoff_cnt <= 1'b0;
                end
                HOLDOFF: begin
                    if (holdoff_cnt) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                    end else begin
                        holdoff_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_collector.sv
// Self-checking bench for nonce_collector: macro model, queue scoreboard and directed scenarios.
// Expectations follow NONCE_COLLECTOR_OVERWRITE_EN when it is defined for the build.
module tb_nonce_collector;
    localparam int         NM    = 4;
    localparam int         DEPTH = 4;
    localparam logic [5:0] BASE  = 6'h00;

    logic        SPI_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        scan_enable = 1'b0;
    logic        pop = 1'b0;
    logic        overflow_clear = 1'b0;
    logic [3:0]  DATA_AVAILABLE = '0;
    logic [3:0]  da_set = '0;
    logic [7:0]  DATA_FROM_HASH = '0;
    logic [3:0]  MACRO_RD_SELECT;
    logic [5:0]  HASH_ADDR;
    logic        head_valid;
    logic [3:0]  head_macro;
    logic [31:0] head_nonce;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        irq;

    logic [31:0] mem [NM];
    int n_cmp = 0;
    int n_err = 0;

    always #5 SPI_CLK = ~SPI_CLK;

    nonce_collector #(.NUM_MACROS(NM), .NONCE_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .SPI_CLK(SPI_CLK), .RST(RST), .scan_enable(scan_enable),
        .DATA_AVAILABLE(DATA_AVAILABLE), .MACRO_RD_SELECT(MACRO_RD_SELECT),
        .HASH_ADDR(HASH_ADDR), .DATA_FROM_HASH(DATA_FROM_HASH), .pop(pop),
        .head_valid(head_valid), .head_macro(head_macro), .head_nonce(head_nonce),
        .fifo_count(fifo_count), .overflow(overflow), .overflow_clear(overflow_clear),
        .irq(irq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge SPI_CLK);
    endtask

    // Hash macros: registered read port, flag raised by the bench, cleared when byte 3 is read.
    always @(posedge SPI_CLK) begin : macro_model
        logic [3:0] clr;
        logic [7:0] d;
        logic [5:0] off;
        clr = '0;
        d   = '0;
        off = HASH_ADDR - BASE;
        for (int m = 0; m < NM; m++) begin
            if (MACRO_RD_SELECT[m]) begin
                if (off < 6'd4) d = mem[m][8*off +: 8];
                if (off == 6'd3) clr[m] = 1'b1;
            end
        end
        DATA_FROM_HASH <= d;
        DATA_AVAILABLE <= (DATA_AVAILABLE | da_set) & ~clr;
    end

    // Scoreboard: an entry is owed two edges after byte 3 of a nonce is first requested.
    logic [35:0] q[$];
    logic        m_ovf = 1'b0;
    int          pend_cnt = 0;
    logic [35:0] pend_entry = '0;
    logic        prev_b3 = 1'b0;

    always @(posedge SPI_CLK) begin : scoreboard
        logic pop_eff, do_push, set_ovf, b3;
        if (RST) begin
            q.delete();
            m_ovf    = 1'b0;
            pend_cnt = 0;
            prev_b3  = 1'b0;
        end else begin
            pop_eff = pop && (q.size() != 0);
            do_push = 1'b0;
            set_ovf = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                do_push = (pend_cnt == 0);
            end
            if (pop_eff) void'(q.pop_front());
            if (do_push) begin
`ifdef NONCE_COLLECTOR_OVERWRITE_EN
                if (q.size() == DEPTH) begin
                    void'(q.pop_front());
                    set_ovf = 1'b1;
                end
`endif
                q.push_back(pend_entry);
            end
            if (set_ovf) m_ovf = 1'b1;
            else if (overflow_clear) m_ovf = 1'b0;
            b3 = (MACRO_RD_SELECT != 4'd0) && (HASH_ADDR == BASE + 6'd3);
            if (b3 && !prev_b3) begin
                pend_cnt = 2;
                for (int m = 0; m < NM; m++)
                    if (MACRO_RD_SELECT[m]) pend_entry = {4'(m), mem[m]};
            end
            prev_b3 = b3;
        end
    end

    always @(negedge SPI_CLK) begin : compare
        logic [35:0] h;
        h = (q.size() != 0) ? q[0] : 36'd0;
        check("head_valid", head_valid, q.size() != 0);
        check("irq", irq, q.size() != 0);
        check("fifo_count", fifo_count, q.size());
        check("head_macro", head_macro, h[35:32]);
        check("head_nonce", head_nonce, h[31:0]);
        check("overflow", overflow, m_ovf);
        check("sel_onehot0", $onehot0(MACRO_RD_SELECT), 1);
    end

    task automatic raise(input logic [3:0] mask);
        da_set = mask;
        tick();
        da_set = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && head_valid; i++) begin
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        check("drain_empty", head_valid, 0);
    endtask

    task automatic reset_pulse();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < NM; m++) mem[m] = '0;
        tick();
        check("rst_sel", MACRO_RD_SELECT, 0);
        check("rst_addr", HASH_ADDR, 0);
        check("rst_hv", head_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_irq", irq, 0);
        check("rst_ovf", overflow, 0);
        tick();
        RST = 1'b0;

        // Single result from macro 2, address sequence and T+7 latency.
        mem[2] = 32'h12345678;
        scan_enable = 1'b1;
        raise(4'b0100);
        for (int i = 0; i < 20 && MACRO_RD_SELECT == 0; i++) tick();
        check("single_to", MACRO_RD_SELECT != 0, 1);
        check("addr_sel", MACRO_RD_SELECT, 4'b0100);
        check("addr_a0", HASH_ADDR, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("read_sel", MACRO_RD_SELECT, 4'b0100);
            check("read_addr", HASH_ADDR, k + 1);
        end
        tick();
        check("read3_sel", MACRO_RD_SELECT, 4'b0100);
        tick();
        check("push_sel", MACRO_RD_SELECT, 0);
        check("push_addr", HASH_ADDR, 0);
        check("push_hv", head_valid, 0);
        tick();
        check("t7_hv", head_valid, 1);
        check("t7_irq", irq, 1);
        check("t7_macro", head_macro, 2);
        check("t7_nonce", head_nonce, 32'h12345678);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pop_hv", head_valid, 0);
        check("pop_irq", irq, 0);

        // Round-robin from ptr 0, all four flags pending.
        scan_enable = 1'b0;
        reset_pulse();
        mem[0] = 32'hDEAD0000; mem[1] = 32'hBEEF0001;
        mem[2] = 32'hCAFE0002; mem[3] = 32'hF00D0003;
        raise(4'b1111);
        scan_enable = 1'b1;
        for (int i = 0; i < 100 && fifo_count != 4; i++) tick();
        check("rr_to", fifo_count, 4);
        check("rr_flags", DATA_AVAILABLE, 0);
        check("rr_head", head_macro, 0);
        check("rr_nonce", head_nonce, 32'hDEAD0000);
        repeat (12) tick();
        check("rr_noreread", fifo_count, 4);

        // Push coinciding with pop.
`ifndef NONCE_COLLECTOR_OVERWRITE_EN
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pp_prehead", head_macro, 1);
`endif
        mem[0] = 32'h5EED0000;
        raise(4'b0001);
        for (int i = 0; i < 50 && MACRO_RD_SELECT == 0; i++) tick();
        check("pp_to_a", MACRO_RD_SELECT != 0, 1);
        for (int i = 0; i < 20 && MACRO_RD_SELECT != 0; i++) tick();
        check("pp_to_b", MACRO_RD_SELECT, 0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pp_ovf", overflow, 0);
`ifdef NONCE_COLLECTOR_OVERWRITE_EN
        check("pp_count", fifo_count, 4);
        check("pp_head", head_macro, 1);
`else
        check("pp_count", fifo_count, 3);
        check("pp_head", head_macro, 2);
`endif
        drain();

        // Five results with no pops.
        scan_enable = 1'b0;
        reset_pulse();
        mem[0] = 32'h11110000; mem[1] = 32'h22220001;
        mem[2] = 32'h33330002; mem[3] = 32'h44440003;
        raise(4'b1111);
        scan_enable = 1'b1;
        for (int i = 0; i < 30 && !head_valid; i++) tick();
        check("full_to_a", head_valid, 1);
        mem[0] = 32'h55550005;
        raise(4'b0001);
`ifdef NONCE_COLLECTOR_OVERWRITE_EN
        for (int i = 0; i < 100 && !overflow; i++) tick();
        check("ow_ovf", overflow, 1);
        check("ow_count", fifo_count, 4);
        check("ow_head", head_macro, 1);
        check("ow_nonce", head_nonce, 32'h22220001);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ow_clear", overflow, 0);
`else
        for (int i = 0; i < 100 && fifo_count != 4; i++) tick();
        check("bp_to", fifo_count, 4);
        repeat (15) tick();
        check("bp_count", fifo_count, 4);
        check("bp_sel", MACRO_RD_SELECT, 0);
        check("bp_flag", DATA_AVAILABLE, 4'b0001);
        check("bp_head", head_nonce, 32'h11110000);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("bp_pop_count", fifo_count, 3);
        tick();
        check("bp_resume_sel", MACRO_RD_SELECT, 4'b0001);
        for (int i = 0; i < 30 && fifo_count != 4; i++) tick();
        check("bp_refill", fifo_count, 4);
        check("bp_head2", head_macro, 1);
`endif
        drain();

        // Reset during READ k=1, then re-read of the still-flagged macro.
        mem[3] = 32'h87654321;
        raise(4'b1000);
        for (int i = 0; i < 20 && MACRO_RD_SELECT == 0; i++) tick();
        check("mid_sel", MACRO_RD_SELECT, 4'b1000);
        tick();
        tick();
        check("mid_addr_k1", HASH_ADDR, 2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_sel", MACRO_RD_SELECT, 0);
        check("mid_rst_addr", HASH_ADDR, 0);
        check("mid_rst_hv", head_valid, 0);
        check("mid_rst_cnt", fifo_count, 0);
        check("mid_flag_kept", DATA_AVAILABLE, 4'b1000);
        for (int i = 0; i < 30 && !head_valid; i++) tick();
        check("mid_to", head_valid, 1);
        check("mid_macro", head_macro, 3);
        check("mid_nonce", head_nonce, 32'h87654321);
        check("mid_flag_clr", DATA_AVAILABLE, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nonce_collector.md
# nonce_collector

Autonomous result harvester between the hash macro array and `regBank`. Scans the macros' `DATA_AVAILABLE` flags round-robin, reads each winning 32-bit nonce over the shared macro read port, and queues `{macro index, nonce}` entries in a small FIFO. The register bank pops entries for SPI readout. Firmware no longer has to poll every macro over SPI.

## Interface
Parameters:
- `NUM_MACROS`, default 4: number of hash macros; equals `NUMBER_OF_MACROS`; range 1..16.
- `NONCE_BASE`, default 6'h00: macro `HASH_ADDR` of nonce byte 0; bytes 1..3 follow at +1..+3.
- `FIFO_DEPTH`, default 4: entry count; power of two, 2..16.

Ports:
- `SPI_CLK`  in  1  block clock (S1 domain).
- `RST`  in  1  synchronous, active-high reset.
- `scan_enable`  in  1  high = collector owns the macro read port and scans.
- `DATA_AVAILABLE`  in  NUM_MACROS  per-macro "nonce found" flags.
- `MACRO_RD_SELECT`  out  NUM_MACROS  one-hot read select; all-zero when not reading.
- `HASH_ADDR`  out  6  macro read address.
- `DATA_FROM_HASH`  in  8  read data; valid one cycle after address/select.
- `pop`  in  1  single-cycle strobe from `regBank`; removes the head entry.
- `head_valid`  out  1  FIFO non-empty.
- `head_macro`  out  4  macro index of the head entry.
- `head_nonce`  out  32  nonce of the head entry; byte 0 in [7:0].
- `fifo_count`  out  5  current occupancy, 0..FIFO_DEPTH.
- `overflow`  out  1  sticky overflow flag.
- `overflow_clear`  in  1  clears `overflow`.
- `irq`  out  1  high whenever `head_valid` is high.

## Operation
- States: IDLE, ADDR, READ, PUSH, HOLDOFF.
- IDLE:
  - `ptr` (0..NUM_MACROS-1) names the macro under examination.
  - Go to ADDR if `scan_enable` && `DATA_AVAILABLE[ptr]` && FIFO can accept.
  - Otherwise, if `scan_enable` is high, advance `ptr` (wrap to 0 after NUM_MACROS-1).
- ADDR: drive `MACRO_RD_SELECT` = one-hot(`ptr`) and `HASH_ADDR` = NONCE_BASE.
- READ, byte counter k = 0..3:
  - Each cycle, capture `DATA_FROM_HASH` into nonce byte k.
  - While k < 3, present `HASH_ADDR` = NONCE_BASE+k+1.
  - After k = 3, go to PUSH.
  - Select stays asserted throughout ADDR and READ.
- PUSH:
  - Write `{ptr, nonce}` at the FIFO tail.
  - Deassert select; `HASH_ADDR` returns to 0.
  - Go to HOLDOFF.
- HOLDOFF:
  - Lasts 2 cycles. The macro clears its flag on the read of NONCE_BASE+3, and HOLDOFF keeps the collector from re-sampling a stale flag.
  - Then advance `ptr` and return to IDLE.
- `scan_enable` falling mid-read: the current read completes and is pushed, then the FSM parks in IDLE. Reads are never abandoned.
- FIFO boundary rules:
  - Pop when empty: ignored.
  - Push and pop in the same cycle: both occur; count unchanged. This also applies when full.
  - Head/tail pointers wrap modulo FIFO_DEPTH.
- `overflow`:
  - Set only by an overwrite (see Configuration).
  - Cleared by `overflow_clear`; if clear and set occur in the same cycle, set wins.
- Reset mid-operation: FIFO emptied, FSM to IDLE, `ptr` = 0, select dropped on the next edge. An in-flight nonce is lost.

## Timing
- Reset values: `MACRO_RD_SELECT` 0, `HASH_ADDR` 0, `head_valid` 0, `head_macro` 0, `head_nonce` 0, `fifo_count` 0, `overflow` 0, `irq` 0.
- All outputs are registered.
- Latency: flag sampled in IDLE at cycle T, then ADDR at T+1, READ at T+2..T+5, PUSH at T+6. `head_valid`/`fifo_count` update visible at T+7.
- Macro-to-macro throughput: 9 cycles per nonce (IDLE, ADDR, 4×READ, PUSH, 2×HOLDOFF).
- `pop` takes effect on its edge. New head data is valid the following cycle.
- Empty flag scan: one macro per cycle, so NUM_MACROS cycles for a full sweep.

## Configuration
- `NONCE_COLLECTOR_OVERWRITE_EN` defined:
  - "FIFO can accept" is always true.
  - A PUSH into a full FIFO without a simultaneous pop discards the oldest entry (head advances), writes the new one, and sets `overflow`.
  - `fifo_count` stays at FIFO_DEPTH.
- Not defined:
  - "FIFO can accept" means `fifo_count` < FIFO_DEPTH. When full, IDLE holds without advancing `ptr`, and nonces stay in the macros (back-pressure).
  - `overflow` is tied 0.

## Test plan
- Single result: `DATA_AVAILABLE`=4'b0100, macro 2 returns bytes 0x78,0x56,0x34,0x12 → `MACRO_RD_SELECT`=4'b0100 during ADDR/READ; `head_macro`=2, `head_nonce`=0x12345678, `irq`=1 at T+7; then `pop` → `head_valid`=0, `irq`=0.
- Round-robin fairness: all four flags high, each flag drops after its nonce read → entries pushed in order 0,1,2,3 (from `ptr`=0); no macro read twice.
- Full FIFO, overwrite undefined: 5 pending results, no pops → `fifo_count`=4 and select idle; macro 0 (5th) stays unread; one `pop` → its read starts within 2 cycles.
- Full FIFO, `NONCE_COLLECTOR_OVERWRITE_EN` defined: 5 results, no pops → `fifo_count`=4, first entry lost, `overflow`=1; `overflow_clear` → 0.
- Simultaneous push/pop at `fifo_count`=4 → count stays 4, no overflow, head advances.
- `RST` pulsed during READ k=1 → next cycle all outputs at reset values; rescan from `ptr`=0 re-reads the still-flagged macro correctly.
